// File: rtl/mlsu_pkg.sv
// Shared MLSU types and sizing constants.
package mlsu_pkg;

  // Global metadata captured per fragmented matrix request.
  typedef struct packed {
    logic       is_store;
    logic [2:0] elem_size;
    logic [3:0] frag_id;
  } meta_glb_t;

  localparam int unsigned MetaGlbW     = $bits(meta_glb_t);
  localparam int unsigned MetaBufDepth = 4;

endpackage : mlsu_pkg

// File: rtl/mlsu_meta_buffer_if.sv
// Enqueue / issue / retire bundle around the MLSU metadata buffer.
interface mlsu_meta_buffer_if
  import mlsu_pkg::*;
#(
  parameter int unsigned Depth = MetaBufDepth
);

  localparam int unsigned CntW = $clog2(Depth + 1);

  logic            meta_ctrl_valid_i;
  logic            meta_ctrl_ready_o;
  meta_glb_t       meta_glb_i;
  logic            issue_valid_o;
  logic            issue_ready_i;
  meta_glb_t       issue_meta_o;
  logic            retire_i;
  meta_glb_t       retire_meta_o;
  logic            retire_valid_o;
  logic [CntW-1:0] occupancy_o;
  logic            idle_o;

  // Control machine + data controller side.
  modport master (
    output meta_ctrl_valid_i, meta_glb_i, issue_ready_i, retire_i,
    input  meta_ctrl_ready_o, issue_valid_o, issue_meta_o,
           retire_meta_o, retire_valid_o, occupancy_o, idle_o
  );

  // Buffer side.
  modport slave (
    input  meta_ctrl_valid_i, meta_glb_i, issue_ready_i, retire_i,
    output meta_ctrl_ready_o, issue_valid_o, issue_meta_o,
           retire_meta_o, retire_valid_o, occupancy_o, idle_o
  );

endinterface : mlsu_meta_buffer_if

// File: rtl/mlsu_meta_buffer.sv
// In-order metadata buffer: records stay resident from enqueue until the
// data controller retires them; issue and retire walk separate pointers.
module mlsu_meta_buffer
  import mlsu_pkg::*;
#(
  parameter int unsigned Depth = MetaBufDepth
) (
  input  logic                clk_i,
  input  logic                rst_i,
  mlsu_meta_buffer_if.slave   bus
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  meta_glb_t       mem [Depth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] iss_ptr;
  logic [PtrW-1:0] ret_ptr;
  logic [CntW-1:0] occ;
  logic [CntW-1:0] pend;

  logic ready;
  logic issue_valid;
  logic retire_valid;
  logic enq_fire;
  logic iss_fire;
  logic ret_fire;

  // Status decoded purely from registered counters; no input reaches an output.
  assign ready        = (occ != CntW'(Depth));
  assign issue_valid  = (pend != '0);
  assign retire_valid = (occ != pend);

  assign enq_fire = bus.meta_ctrl_valid_i && ready;
  assign iss_fire = bus.issue_ready_i && issue_valid;
  assign ret_fire = bus.retire_i && retire_valid;

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      iss_ptr <= '0;
      ret_ptr <= '0;
      occ     <= '0;
      pend    <= '0;
    end else begin
      if (enq_fire) wr_ptr  <= wr_ptr + PtrW'(1);
      if (iss_fire) iss_ptr <= iss_ptr + PtrW'(1);
      if (ret_fire) ret_ptr <= ret_ptr + PtrW'(1);
      occ  <= occ + CntW'(enq_fire) - CntW'(ret_fire);
      pend <= pend + CntW'(enq_fire) - CntW'(iss_fire);
    end
  end

  // Entry storage; contents are intentionally left unreset.
  always_ff @(posedge clk_i) begin
    if (enq_fire) mem[wr_ptr] <= bus.meta_glb_i;
  end

  assign bus.meta_ctrl_ready_o = ready;
  assign bus.issue_valid_o     = issue_valid;
  assign bus.retire_valid_o    = retire_valid;
  assign bus.occupancy_o       = occ;
  assign bus.idle_o            = (occ == '0);
  assign bus.issue_meta_o      = mem[iss_ptr];
  assign bus.retire_meta_o     = mem[ret_ptr];

  // A retire with nothing issued is dropped; flag it so the caller bug is visible.
  a_retire_legal : assert property (@(posedge clk_i) disable iff (rst_i)
                                    !(bus.retire_i && !retire_valid))
    else $warning("mlsu_meta_buffer: retire_i with no issued record, ignored");

endmodule : mlsu_meta_buffer

// File: tb/tb_mlsu_meta_buffer.sv
// Bench for mlsu_meta_buffer: queue model + per-cycle compare + directed checks.
module tb_mlsu_meta_buffer;
  import mlsu_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst;

  int n_cmp = 0;
  int n_err = 0;

  mlsu_meta_buffer_if #(.Depth(DEPTH)) bus ();

  mlsu_meta_buffer #(.Depth(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: list of resident records, oldest first; the first n_iss have been issued.
  meta_glb_t m_q[$];
  int        m_iss;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_iss = 0;
    end else begin
      bit do_enq, do_iss, do_ret;
      do_enq = bus.meta_ctrl_valid_i && (m_q.size() < DEPTH);
      do_iss = bus.issue_ready_i && (m_iss < m_q.size());
      do_ret = bus.retire_i && (m_iss > 0);
      if (do_ret) begin
        void'(m_q.pop_front());
        m_iss--;
      end
      if (do_iss) m_iss++;
      if (do_enq) m_q.push_back(bus.meta_glb_i);
    end
  end

  // Every-cycle comparison against the model, mid-way between edges.
  always @(negedge clk) begin
    chk("ready",        32'(bus.meta_ctrl_ready_o), 32'(m_q.size() < DEPTH));
    chk("issue_valid",  32'(bus.issue_valid_o),     32'(m_iss < m_q.size()));
    chk("retire_valid", 32'(bus.retire_valid_o),    32'(m_iss > 0));
    chk("occupancy",    32'(bus.occupancy_o),       32'(m_q.size()));
    chk("idle",         32'(bus.idle_o),            32'(m_q.size() == 0));
    if (m_iss < m_q.size()) chk("issue_meta",  32'(bus.issue_meta_o),  32'(m_q[m_iss]));
    if (m_iss > 0)          chk("retire_meta", 32'(bus.retire_meta_o), 32'(m_q[0]));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},        32'(bus.meta_ctrl_ready_o), 32'd1);
    chk({tag, "_issue_valid"},  32'(bus.issue_valid_o),     32'd0);
    chk({tag, "_retire_valid"}, 32'(bus.retire_valid_o),    32'd0);
    chk({tag, "_occupancy"},    32'(bus.occupancy_o),       32'd0);
    chk({tag, "_idle"},         32'(bus.idle_o),            32'd1);
  endtask

  initial begin
    rst = 1'b1;
    bus.meta_ctrl_valid_i = 1'b0;
    bus.meta_glb_i        = '0;
    bus.issue_ready_i     = 1'b0;
    bus.retire_i          = 1'b0;
    step();
    step();
    chk_reset_outputs("rst");
    rst = 1'b0;

    // Single record 0x11 through enqueue, issue, retire.
    bus.meta_ctrl_valid_i = 1'b1;
    bus.meta_glb_i        = meta_glb_t'(8'h11);
    step();
    bus.meta_ctrl_valid_i = 1'b0;
    chk("one_issue_valid", 32'(bus.issue_valid_o), 32'd1);
    chk("one_issue_meta",  32'(bus.issue_meta_o),  32'h11);
    chk("one_occ",         32'(bus.occupancy_o),   32'd1);
    bus.issue_ready_i = 1'b1;
    step();
    bus.issue_ready_i = 1'b0;
    chk("one_retire_valid", 32'(bus.retire_valid_o), 32'd1);
    chk("one_retire_meta",  32'(bus.retire_meta_o),  32'h11);
    bus.retire_i = 1'b1;
    step();
    bus.retire_i = 1'b0;
    chk("one_idle", 32'(bus.idle_o), 32'd1);

    // Fill to Depth, hold a fifth record against a full buffer.
    for (int i = 1; i <= 4; i++) begin
      bus.meta_ctrl_valid_i = 1'b1;
      bus.meta_glb_i        = meta_glb_t'(8'(i));
      step();
    end
    chk("full_ready", 32'(bus.meta_ctrl_ready_o), 32'd0);
    chk("full_occ",   32'(bus.occupancy_o),       32'd4);
    bus.meta_glb_i = meta_glb_t'(8'h05);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_hold_occ",  32'(bus.occupancy_o),  32'd4);
      chk("full_hold_head", 32'(bus.issue_meta_o), 32'h01);
    end
    bus.issue_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) step();
    bus.issue_ready_i = 1'b0;
    chk("full_all_issued", 32'(bus.issue_valid_o),     32'd0);
    chk("full_still_full", 32'(bus.meta_ctrl_ready_o), 32'd0);
    bus.retire_i = 1'b1;
    step();
    bus.retire_i = 1'b0;
    chk("free_ready_next", 32'(bus.meta_ctrl_ready_o), 32'd1);
    chk("free_no_same_cy", 32'(bus.occupancy_o),       32'd3);
    chk("free_retire_hd",  32'(bus.retire_meta_o),     32'h02);
    step();
    bus.meta_ctrl_valid_i = 1'b0;
    chk("fifth_in_occ",  32'(bus.occupancy_o),  32'd4);
    chk("fifth_in_meta", 32'(bus.issue_meta_o), 32'h05);
    bus.issue_ready_i = 1'b1;
    step();
    bus.issue_ready_i = 1'b0;
    bus.retire_i = 1'b1;
    for (int i = 0; i < 4; i++) step();
    bus.retire_i = 1'b0;
    chk("fill_drained", 32'(bus.idle_o), 32'd1);

    // Wrap: 10 records streamed with issue and retire every cycle.
    bus.issue_ready_i = 1'b1;
    bus.retire_i      = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.meta_ctrl_valid_i = (i < 10);
      bus.meta_glb_i        = meta_glb_t'(8'(8'h10 + i));
      if (i >= 1 && i <= 10) chk("wrap_issue_order",  32'(bus.issue_meta_o),  32'(8'h10 + i - 1));
      if (i >= 2)            chk("wrap_retire_order", 32'(bus.retire_meta_o), 32'(8'h10 + i - 2));
      step();
    end
    bus.meta_ctrl_valid_i = 1'b0;
    bus.issue_ready_i     = 1'b0;
    bus.retire_i          = 1'b0;
    chk("wrap_idle", 32'(bus.idle_o), 32'd1);

    // Simultaneous enqueue + issue + retire with occ=2, pend=1.
    bus.meta_ctrl_valid_i = 1'b1;
    bus.meta_glb_i        = meta_glb_t'(8'h21);
    step();
    bus.meta_glb_i        = meta_glb_t'(8'h22);
    step();
    bus.meta_ctrl_valid_i = 1'b0;
    bus.issue_ready_i     = 1'b1;
    step();
    bus.meta_ctrl_valid_i = 1'b1;
    bus.meta_glb_i        = meta_glb_t'(8'h23);
    bus.retire_i          = 1'b1;
    step();
    bus.meta_ctrl_valid_i = 1'b0;
    bus.issue_ready_i     = 1'b0;
    bus.retire_i          = 1'b0;
    chk("sim_occ",          32'(bus.occupancy_o),    32'd2);
    chk("sim_issue_valid",  32'(bus.issue_valid_o),  32'd1);
    chk("sim_issue_meta",   32'(bus.issue_meta_o),   32'h23);
    chk("sim_retire_valid", 32'(bus.retire_valid_o), 32'd1);
    chk("sim_retire_meta",  32'(bus.retire_meta_o),  32'h22);

    // Illegal retire: retire 0x22 first so occ=pend=1, then retire again.
    bus.retire_i = 1'b1;
    step();
    bus.retire_i = 1'b1;
    step();
    bus.retire_i = 1'b0;
    chk("illegal_occ",          32'(bus.occupancy_o),    32'd1);
    chk("illegal_issue_meta",   32'(bus.issue_meta_o),   32'h23);
    chk("illegal_retire_valid", 32'(bus.retire_valid_o), 32'd0);

    // Asynchronous reset with three resident records.
    bus.meta_ctrl_valid_i = 1'b1;
    bus.meta_glb_i        = meta_glb_t'(8'h24);
    step();
    bus.meta_glb_i        = meta_glb_t'(8'h25);
    step();
    bus.meta_ctrl_valid_i = 1'b0;
    chk("pre_rst_occ", 32'(bus.occupancy_o), 32'd3);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    bus.meta_ctrl_valid_i = 1'b1;
    bus.meta_glb_i        = meta_glb_t'(8'hAA);
    step();
    bus.meta_ctrl_valid_i = 1'b0;
    chk("post_rst_issue_meta", 32'(bus.issue_meta_o), 32'hAA);
    chk("post_rst_occ",        32'(bus.occupancy_o),  32'd1);
    bus.issue_ready_i = 1'b1;
    step();
    bus.issue_ready_i = 1'b0;
    chk("post_rst_retire_meta", 32'(bus.retire_meta_o), 32'hAA);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mlsu_meta_buffer
